// File: rtl/color_matrix_pipe_if.sv
// color_matrix_pipe_if
//   Valid/ready stream bundle for the colour-matrix stage.
//   Input side : in_valid, in_ready, in_sof, in_pix
//   Output side: out_valid, out_ready, out_sof, out_pix
//   Pixel packing: channel k at [k*PIXEL_WIDTH +: PIXEL_WIDTH].
//   master = stream source / sink environment, slave = the colour-matrix stage.
interface color_matrix_pipe_if #(
  parameter int PIXEL_WIDTH = 16,
  parameter int NUM_CH      = 3
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_sof;
  logic [NUM_CH*PIXEL_WIDTH-1:0] in_pix;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_sof;
  logic [NUM_CH*PIXEL_WIDTH-1:0] out_pix;

  modport master (
    output in_valid, in_sof, in_pix, out_ready,
    input  in_ready, out_valid, out_sof, out_pix
  );

  modport slave (
    input  in_valid, in_sof, in_pix, out_ready,
    output in_ready, out_valid, out_sof, out_pix
  );
endinterface

// File: rtl/color_matrix_pipe.sv
// color_matrix_pipe
//   Pipelined NUM_CH x NUM_CH signed fixed-point colour matrix on a valid/ready
//   stream. Coefficients are double-buffered; the shadow bank is copied into the
//   active bank only on an accepted start-of-frame beat, so a frame never mixes
//   matrices.
//   Pipeline: S1 signed products, S2 row sum + round-half-up, S3 clip to
//   [0, 2**PIXEL_WIDTH-1]. Latency 3 cycles when unstalled; a single global
//   stall (out_valid && !out_ready) freezes every stage.
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   bus (slave)        input/output pixel streams (see color_matrix_pipe_if)
//   coeff_wr_en/addr/data  shadow coefficient write, addr = i*NUM_CH+j
//   coeff_commit       arm shadow->active swap at next accepted sof beat
//   commit_pending     swap armed but not yet taken
//   sat_count          clipped-channel counter (zero unless enabled)
// Optional feature
//   CSC_SAT_COUNT_EN   when defined, sat_count counts clipped channels of each
//                      accepted output beat; saturates, and restarts at each
//                      output sof beat.
module color_matrix_pipe #(
  parameter int PIXEL_WIDTH = 16,
  parameter int FRAC_BITS   = 6,
  parameter int INT_BITS    = 6,
  parameter int NUM_CH      = 3,
  localparam int CW = INT_BITS + FRAC_BITS,
  localparam int AW = (NUM_CH * NUM_CH > 1) ? $clog2(NUM_CH * NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  color_matrix_pipe_if.slave           bus,
  input  logic                         coeff_wr_en,
  input  logic [AW-1:0]                coeff_wr_addr,
  input  logic signed [CW-1:0]         coeff_wr_data,
  input  logic                         coeff_commit,
  output logic                         commit_pending,
  output logic [31:0]                  sat_count
);

  localparam int NC2   = NUM_CH * NUM_CH;
  localparam int PW1   = PIXEL_WIDTH + 1;
  localparam int PRODW = PW1 + CW;
  localparam int SUMW  = PRODW + $clog2(NUM_CH) + 1;

  localparam logic signed [CW-1:0]   COEF_ONE = CW'(2 ** FRAC_BITS);
  localparam logic signed [SUMW-1:0] RND      = SUMW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [SUMW-1:0] MAXV     =
    {{(SUMW - PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

  logic signed [CW-1:0]    shadow_q   [NC2];
  logic signed [CW-1:0]    active_q   [NC2];
  logic signed [CW-1:0]    shadow_nxt [NC2];
  logic signed [CW-1:0]    bank_use   [NC2];
  logic                    pending_q;

  logic                    stall;
  logic                    adv;
  logic                    accept;
  logic                    swap;

  logic                    v1, v2, v3;
  logic                    sof1, sof2, sof3;
  logic signed [PRODW-1:0] prod_c [NUM_CH][NUM_CH];
  logic signed [PRODW-1:0] prod1  [NUM_CH][NUM_CH];
  logic signed [SUMW-1:0]  acc;
  logic signed [SUMW-1:0]  sum_c  [NUM_CH];
  logic signed [SUMW-1:0]  sum2   [NUM_CH];
  logic [NUM_CH*PIXEL_WIDTH-1:0] pix_c;
  logic [NUM_CH*PIXEL_WIDTH-1:0] pix3;

  // Handshake and global stall
  assign stall         = v3 && !bus.out_ready;
  assign adv           = !stall;
  assign bus.in_ready  = adv;
  assign accept        = bus.in_valid && adv;
  // A commit arriving with the sof beat itself is taken immediately.
  assign swap          = accept && bus.in_sof && (pending_q || coeff_commit);

  assign bus.out_valid = v3;
  assign bus.out_sof   = sof3;
  assign bus.out_pix   = pix3;
  assign commit_pending = pending_q;

  // Shadow bank as it will be after this cycle's write; the swap copies this
  // so a write issued together with the commit is part of the new matrix.
  always_comb begin
    for (int k = 0; k < NC2; k++) begin
      shadow_nxt[k] = shadow_q[k];
      if (coeff_wr_en && (int'(coeff_wr_addr) == k)) begin
        shadow_nxt[k] = coeff_wr_data;
      end
    end
  end

  // The swapping sof beat already uses the new bank.
  always_comb begin
    for (int k = 0; k < NC2; k++) begin
      bank_use[k] = swap ? shadow_nxt[k] : active_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NC2; k++) begin
        shadow_q[k] <= ((k / NUM_CH) == (k % NUM_CH)) ? COEF_ONE : '0;
        active_q[k] <= ((k / NUM_CH) == (k % NUM_CH)) ? COEF_ONE : '0;
      end
      pending_q <= 1'b0;
    end else begin
      for (int k = 0; k < NC2; k++) begin
        shadow_q[k] <= shadow_nxt[k];
        if (swap) begin
          active_q[k] <= shadow_nxt[k];
        end
      end
      if (swap) begin
        pending_q <= 1'b0;
      end else if (coeff_commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  // S1: pixel zero-extended to a non-negative signed value, times coefficient
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        prod_c[i][j] =
          PRODW'($signed({1'b0, bus.in_pix[j*PIXEL_WIDTH +: PIXEL_WIDTH]})) *
          PRODW'(bank_use[i*NUM_CH + j]);
      end
    end
  end

  // S2: row sum, round half up, arithmetic shift back to integer
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc = RND;
      for (int j = 0; j < NUM_CH; j++) begin
        acc = acc + SUMW'(prod1[i][j]);
      end
      sum_c[i] = acc >>> FRAC_BITS;
    end
  end

  // S3: clip to the unsigned pixel range
  always_comb begin
    pix_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sum2[i][SUMW-1]) begin
        pix_c[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
      end else if (sum2[i] > MAXV) begin
        pix_c[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '1;
      end else begin
        pix_c[i*PIXEL_WIDTH +: PIXEL_WIDTH] = sum2[i][PIXEL_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      sof1 <= 1'b0;
      sof2 <= 1'b0;
      sof3 <= 1'b0;
      pix3 <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sum2[i] <= '0;
        for (int j = 0; j < NUM_CH; j++) begin
          prod1[i][j] <= '0;
        end
      end
    end else if (adv) begin
      v1   <= accept;
      sof1 <= bus.in_sof;
      v2   <= v1;
      sof2 <= sof1;
      v3   <= v2;
      sof3 <= sof2;
      pix3 <= pix_c;
      for (int i = 0; i < NUM_CH; i++) begin
        sum2[i] <= sum_c[i];
        for (int j = 0; j < NUM_CH; j++) begin
          prod1[i][j] <= prod_c[i][j];
        end
      end
    end
  end

`ifdef CSC_SAT_COUNT_EN
  localparam int CNTW = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] clip3;
  logic [CNTW-1:0]   nclip;
  logic [31:0]       sat_base;
  logic [32:0]       sat_sum;
  logic [31:0]       sat_q;

  // Clip flags travel with the S3 result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip3 <= '0;
    end else if (adv) begin
      for (int i = 0; i < NUM_CH; i++) begin
        clip3[i] <= sum2[i][SUMW-1] || (sum2[i] > MAXV);
      end
    end
  end

  always_comb begin
    nclip = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nclip = nclip + CNTW'(clip3[i]);
    end
    sat_base = sof3 ? 32'd0 : sat_q;
    sat_sum  = {1'b0, sat_base} + 33'(nclip);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= '0;
    end else if (v3 && bus.out_ready) begin
      sat_q <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
    end
  end

  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_color_matrix_pipe.sv
// tb_color_matrix_pipe
//   Scoreboard bench for color_matrix_pipe (3 channels, 16-bit pixels, Q6.6).
//   Expected beats are computed from a bench-side integer model of the
//   coefficient banks when a beat is accepted, and compared when it emerges.
module tb_color_matrix_pipe;
  localparam int PW = 16;
  localparam int NC = 3;
  localparam int FB = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        coeff_wr_en = 1'b0;
  logic [3:0]  coeff_wr_addr = '0;
  logic [11:0] coeff_wr_data = '0;
  logic        coeff_commit = 1'b0;
  logic        commit_pending;
  logic [31:0] sat_count;

  always #5 clk = ~clk;

  color_matrix_pipe_if #(.PIXEL_WIDTH(PW), .NUM_CH(NC)) bus ();

  color_matrix_pipe #(
    .PIXEL_WIDTH(PW), .FRAC_BITS(FB), .INT_BITS(6), .NUM_CH(NC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .coeff_wr_en    (coeff_wr_en),
    .coeff_wr_addr  (coeff_wr_addr),
    .coeff_wr_data  (coeff_wr_data),
    .coeff_commit   (coeff_commit),
    .commit_pending (commit_pending),
    .sat_count      (sat_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] exp_pix_q[$];
  logic [47:0] obs_pix_q[$];
  bit          exp_sof_q[$];
  bit          obs_sof_q[$];
  int          exp_clip_q[$];
  int          exp_cyc_q[$];
  int          obs_cyc_q[$];

  int     m_active[9];
  int     m_shadow[9];
  bit     m_pending;
  longint m_sat;

  // Output monitor: sample well after the falling edge, before the next rise.
  always @(negedge clk) begin
    #3;
    if (!reset && bus.out_valid && bus.out_ready) begin
      obs_pix_q.push_back(bus.out_pix);
      obs_sof_q.push_back(bus.out_sof);
      obs_cyc_q.push_back(cyc);
    end
  end

  function automatic void model_reset();
    for (int k = 0; k < 9; k++) begin
      m_active[k] = ((k / 3) == (k % 3)) ? 64 : 0;
      m_shadow[k] = m_active[k];
    end
    m_pending = 1'b0;
    m_sat     = 0;
  endfunction

  function automatic void predict(input logic [47:0] p, output logic [47:0] r,
                                  output int clips);
    longint acc;
    clips = 0;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      acc = 32;
      for (int j = 0; j < 3; j++) begin
        acc += longint'(m_active[i*3 + j]) * longint'(p[j*16 +: 16]);
      end
      acc = acc >>> 6;
      if (acc < 0) begin
        r[i*16 +: 16] = 16'd0;
        clips++;
      end else if (acc > 65535) begin
        r[i*16 +: 16] = 16'hFFFF;
        clips++;
      end else begin
        r[i*16 +: 16] = 16'(acc);
      end
    end
  endfunction

  // One clock: apply the model effect of this cycle's inputs, then advance.
  task automatic step(input bit acc, input logic [47:0] p, input bit sof);
    logic [47:0] r;
    int c;
    if (coeff_wr_en) m_shadow[coeff_wr_addr] = int'($signed(coeff_wr_data));
    if (acc && sof && (m_pending || coeff_commit)) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (coeff_commit) begin
      m_pending = 1'b1;
    end
    if (acc) begin
      predict(p, r, c);
      exp_pix_q.push_back(r);
      exp_sof_q.push_back(sof);
      exp_clip_q.push_back(c);
      exp_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    coeff_wr_en  = 1'b0;
    coeff_commit = 1'b0;
  endtask

  task automatic send(input logic [47:0] p, input bit sof);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_pix   = p;
    for (int t = 0; t < 100 && !ok; t++) begin
      #1;
      if (bus.in_ready) begin
        step(1'b1, p, sof);
        ok = 1'b1;
      end else begin
        step(1'b0, p, sof);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_accept: beat %h never accepted, in_ready=%b expected 1",
               p, bus.in_ready);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      #1;
      step(1'b0, '0, 1'b0);
    end
  endtask

  task automatic wr_coef(input int addr, input int val);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = 4'(addr);
    coeff_wr_data = 12'(val);
    #1;
    step(1'b0, '0, 1'b0);
  endtask

  task automatic do_commit();
    coeff_commit = 1'b1;
    #1;
    step(1'b0, '0, 1'b0);
  endtask

  task automatic load_matrix(input int m[9]);
    for (int k = 0; k < 9; k++) wr_coef(k, m[k]);
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (obs_pix_q.size() >= exp_pix_q.size()) ok = 1'b1;
      else @(negedge clk);
    end
    idle(3);
  endtask

  task automatic pop_beat(output logic [47:0] ep, output logic [47:0] op,
                          output bit es, output bit os, output int lat);
    int c;
    ep  = exp_pix_q.pop_front();
    op  = obs_pix_q.pop_front();
    es  = exp_sof_q.pop_front();
    os  = obs_sof_q.pop_front();
    c   = exp_clip_q.pop_front();
    lat = obs_cyc_q.pop_front() - exp_cyc_q.pop_front();
    if (es) m_sat = 0;
    m_sat += c;
    if (m_sat > 64'hFFFF_FFFF) m_sat = 64'hFFFF_FFFF;
  endtask

  function automatic logic [47:0] px(input int r, input int g, input int b);
    return {16'(b), 16'(g), 16'(r)};
  endfunction

  // Shared per-test drain: every remaining expected beat against the monitor.
  logic [47:0] ep, op;
  bit          es, os, ok;
  int          lat;

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_pix    = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", commit_pending); end
    n_checks++; if (sat_count !== 32'd0) begin n_fail++; $display("FAIL reset_sat got %0d want 0", sat_count); end
    n_checks++; if (bus.out_pix !== 48'd0) begin n_fail++; $display("FAIL reset_out_pix got %h want 0", bus.out_pix); end
    n_checks++; if (bus.out_sof !== 1'b0) begin n_fail++; $display("FAIL reset_out_sof got %b want 0", bus.out_sof); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    send(px(1000, 2000, 3000), 1'b1);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL identity_drain got %0d beats want %0d", obs_pix_q.size(), exp_pix_q.size()); end
    while (exp_pix_q.size() > 0 && obs_pix_q.size() > 0) begin
      pop_beat(ep, op, es, os, lat);
      n_checks++; if (op !== px(1000, 2000, 3000)) begin n_fail++; $display("FAIL identity_pix got %h want %h", op, px(1000, 2000, 3000)); end
      n_checks++; if (op !== ep) begin n_fail++; $display("FAIL identity_model got %h want %h", op, ep); end
      n_checks++; if (os !== es) begin n_fail++; $display("FAIL identity_sof got %b want %b", os, es); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL identity_latency got %0d want 3", lat); end
    end
  endtask

  task automatic test_rounding();
    int m[9];
    int want[3];
    int idx;
    m = '{32, 0, 0, 0, 0, 0, 0, 0, 0};
    want = '{2, 1, 1};
    load_matrix(m);
    do_commit();
    n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL round_pending got %b want 1", commit_pending); end
    send(px(3, 7, 9), 1'b1);
    send(px(2, 0, 0), 1'b0);
    send(px(1, 0, 0), 1'b0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL round_drain got %0d beats want %0d", obs_pix_q.size(), exp_pix_q.size()); end
    idx = 0;
    while (exp_pix_q.size() > 0 && obs_pix_q.size() > 0) begin
      pop_beat(ep, op, es, os, lat);
      n_checks++; if (op !== ep) begin n_fail++; $display("FAIL round_pix beat %0d got %h want %h", idx, op, ep); end
      n_checks++; if (op[15:0] !== 16'(want[idx])) begin n_fail++; $display("FAIL round_r beat %0d got %0d want %0d", idx, op[15:0], want[idx]); end
      idx++;
    end
  endtask

  task automatic test_clip();
    longint exp_sat;
    wr_coef(0, -64);
    do_commit();
    send(px(500, 0, 0), 1'b1);
    wr_coef(0, 128);
    do_commit();
    send(px(40000, 100, 100), 1'b1);
    send(px(40000, 5, 5), 1'b0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clip_drain got %0d beats want %0d", obs_pix_q.size(), exp_pix_q.size()); end
    while (exp_pix_q.size() > 0 && obs_pix_q.size() > 0) begin
      pop_beat(ep, op, es, os, lat);
      n_checks++; if (op !== ep) begin n_fail++; $display("FAIL clip_pix got %h want %h", op, ep); end
      n_checks++; if (os !== es) begin n_fail++; $display("FAIL clip_sof got %b want %b", os, es); end
    end
    exp_sat = m_sat;
`ifndef CSC_SAT_COUNT_EN
    exp_sat = 0;
`endif
    n_checks++; if (sat_count !== 32'(exp_sat)) begin n_fail++; $display("FAIL clip_sat_count got %0d want %0d", sat_count, exp_sat); end
  endtask

  task automatic test_backpressure();
    int m[9];
    int idx;
    m = '{64, 10, -5, -20, 80, 3, 30, -30, 100};
    load_matrix(m);
    do_commit();
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          send(px($urandom_range(0, 65535), $urandom_range(0, 65535),
                  $urandom_range(0, 65535)), b == 0);
        end
      end
      begin
        logic [47:0] held;
        for (int t = 0; t < 100 && obs_pix_q.size() < 3; t++) @(negedge clk);
        bus.out_ready = 1'b0;
        #2;
        held = bus.out_pix;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b want 1", bus.out_valid); end
        for (int k = 0; k < 5; k++) begin
          if (k > 0) #2;
          n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, bus.in_ready); end
          n_checks++; if (bus.out_pix !== held) begin n_fail++; $display("FAIL bp_hold cycle %0d got %h want %h", k, bus.out_pix, held); end
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_drain got %0d beats want %0d", obs_pix_q.size(), exp_pix_q.size()); end
    n_checks++; if (obs_pix_q.size() !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", obs_pix_q.size()); end
    idx = 0;
    while (exp_pix_q.size() > 0 && obs_pix_q.size() > 0) begin
      pop_beat(ep, op, es, os, lat);
      n_checks++; if (op !== ep) begin n_fail++; $display("FAIL bp_pix beat %0d got %h want %h", idx, op, ep); end
      n_checks++; if (os !== es) begin n_fail++; $display("FAIL bp_sof beat %0d got %b want %b", idx, os, es); end
      idx++;
    end
  endtask

  task automatic test_commit();
    int m[9];
    int idx;
    m = '{0, 0, 64, 0, 64, 0, 64, 0, 0};
    load_matrix(m);
    n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL commit_pre got %b want 0", commit_pending); end
    do_commit();
    n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_armed got %b want 1", commit_pending); end
    send(px(1000, 2000, 3000), 1'b0);
    send(px(4000, 5000, 6000), 1'b0);
    n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_midframe got %b want 1", commit_pending); end
    send(px(1000, 2000, 3000), 1'b1);
    n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL commit_taken got %b want 0", commit_pending); end
    send(px(7000, 8000, 9000), 1'b0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL commit_drain got %0d beats want %0d", obs_pix_q.size(), exp_pix_q.size()); end
    idx = 0;
    while (exp_pix_q.size() > 0 && obs_pix_q.size() > 0) begin
      pop_beat(ep, op, es, os, lat);
      n_checks++; if (op !== ep) begin n_fail++; $display("FAIL commit_pix beat %0d got %h want %h", idx, op, ep); end
      idx++;
    end
    // sof beat under the swapped matrix: R and B exchanged
    n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL commit_count got %0d want 4", idx); end
  endtask

  task automatic test_same_cycle();
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = 4'd0;
    coeff_wr_data = 12'd32;
    coeff_commit  = 1'b1;
    send(px(1000, 2000, 3000), 1'b1);
    n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL same_pending got %b want 0", commit_pending); end
    send(px(600, 700, 800), 1'b0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL same_drain got %0d beats want %0d", obs_pix_q.size(), exp_pix_q.size()); end
    while (exp_pix_q.size() > 0 && obs_pix_q.size() > 0) begin
      pop_beat(ep, op, es, os, lat);
      n_checks++; if (op !== ep) begin n_fail++; $display("FAIL same_pix got %h want %h", op, ep); end
    end
  endtask

  task automatic test_reset_midstream();
    do_commit();
    bus.out_ready = 1'b0;
    send(px(11, 22, 33), 1'b0);
    send(px(44, 55, 66), 1'b0);
    send(px(77, 88, 99), 1'b0);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending got %b want 0", commit_pending); end
    n_checks++; if (sat_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_sat got %0d want 0", sat_count); end
    n_checks++; if (bus.out_pix !== 48'd0) begin n_fail++; $display("FAIL rstmid_out_pix got %h want 0", bus.out_pix); end
    model_reset();
    exp_pix_q.delete(); exp_sof_q.delete(); exp_clip_q.delete(); exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    idle(6);
    n_checks++; if (obs_pix_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_stale got %0d beats want 0", obs_pix_q.size()); end
    obs_pix_q.delete(); obs_sof_q.delete(); obs_cyc_q.delete();
    send(px(300, 200, 100), 1'b1);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_drain got %0d beats want %0d", obs_pix_q.size(), exp_pix_q.size()); end
    while (exp_pix_q.size() > 0 && obs_pix_q.size() > 0) begin
      pop_beat(ep, op, es, os, lat);
      n_checks++; if (op !== px(300, 200, 100)) begin n_fail++; $display("FAIL rstmid_identity got %h want %h", op, px(300, 200, 100)); end
      n_checks++; if (op !== ep) begin n_fail++; $display("FAIL rstmid_model got %h want %h", op, ep); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rounding();
    test_clip();
    test_backpressure();
    test_commit();
    test_same_cycle();
    test_reset_midstream();
    n_checks++;
    if (obs_pix_q.size() !== 0) begin
      n_fail++;
      $display("FAIL extra_beats got %0d unexpected beats want 0", obs_pix_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end
endmodule
